// File: rtl/control_sequencer.sv
// T-state control sequencer for a simple accumulator CPU: fetches over T1-T3,
// executes over T4-T6 (or fewer when EARLY_END=1), and parks in HALT on HLT.
module control_sequencer #(
  parameter bit EARLY_END = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       run,
  input  logic       step_mode,
  input  logic       step,
  input  logic [3:0] ir_opcode,
  output logic       pc_inc,
  output logic       pc_oe,
  output logic       mar_we,
  output logic       mem_oe,
  output logic       ir_we,
  output logic       ir_oe,
  output logic       acc_we,
  output logic       acc_oe,
  output logic       breg_we,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       or_we,
  output logic [2:0] t_state,
  output logic       halted,
  output logic       instr_done,
  output logic [7:0] instr_count
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] op_q;
  logic [3:0] op_dec;
  logic [7:0] count;
  logic       step_q;
  logic       step_rise;
  logic       adv;
  logic       active;
  logic       last;
  logic       is_alu;
  logic       is_mem;

  logic c_pc_inc, c_pc_oe, c_mar_we, c_mem_oe, c_ir_we, c_ir_oe;
  logic c_acc_we, c_acc_oe, c_breg_we, c_alu_oe, c_alu_sub, c_or_we;

  // T4 sees the opcode straight from the IR; later states use the copy taken in T4.
  always_comb begin
    step_rise = step & ~step_q;
    adv       = run & (step_mode ? step_rise : 1'b1);
    active    = adv & RESET & (state != HALT);
    op_dec    = (state == T4) ? ir_opcode : op_q;
    is_alu    = (op_dec == OP_ADD) || (op_dec == OP_SUB);
    is_mem    = is_alu || (op_dec == OP_LDA);
  end

  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    c_pc_inc  = 1'b0;
    c_pc_oe   = 1'b0;
    c_mar_we  = 1'b0;
    c_mem_oe  = 1'b0;
    c_ir_we   = 1'b0;
    c_ir_oe   = 1'b0;
    c_acc_we  = 1'b0;
    c_acc_oe  = 1'b0;
    c_breg_we = 1'b0;
    c_alu_oe  = 1'b0;
    c_alu_sub = 1'b0;
    c_or_we   = 1'b0;
    case (state)
      T1: begin
        c_pc_oe   = 1'b1;
        c_mar_we  = 1'b1;
        state_nxt = T2;
      end
      T2: begin
        c_pc_inc  = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        c_mem_oe  = 1'b1;
        c_ir_we   = 1'b1;
        state_nxt = T4;
      end
      T4: begin
        if (is_mem) begin
          c_ir_oe  = 1'b1;
          c_mar_we = 1'b1;
        end
        if (op_dec == OP_OUT) begin
          c_acc_oe = 1'b1;
          c_or_we  = 1'b1;
        end
        if (op_dec == OP_HLT) begin
          last      = 1'b1;
          state_nxt = HALT;
        end else if (EARLY_END && !is_mem) begin
          last      = 1'b1;
          state_nxt = T1;
        end else begin
          state_nxt = T5;
        end
      end
      T5: begin
        if (op_dec == OP_LDA) begin
          c_mem_oe = 1'b1;
          c_acc_we = 1'b1;
        end
        if (is_alu) begin
          c_mem_oe  = 1'b1;
          c_breg_we = 1'b1;
          c_alu_sub = (op_dec == OP_SUB);
        end
        if (EARLY_END && (op_dec == OP_LDA)) begin
          last      = 1'b1;
          state_nxt = T1;
        end else begin
          state_nxt = T6;
        end
      end
      T6: begin
        if (is_alu) begin
          c_alu_oe  = 1'b1;
          c_acc_we  = 1'b1;
          c_alu_sub = (op_dec == OP_SUB);
        end
        last      = 1'b1;
        state_nxt = T1;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = T1;
    endcase
  end

  // Control word is live only on cycles that actually advance the sequencer.
  always_comb begin
    pc_inc     = active & c_pc_inc;
    pc_oe      = active & c_pc_oe;
    mar_we     = active & c_mar_we;
    mem_oe     = active & c_mem_oe;
    ir_we      = active & c_ir_we;
    ir_oe      = active & c_ir_oe;
    acc_we     = active & c_acc_we;
    acc_oe     = active & c_acc_oe;
    breg_we    = active & c_breg_we;
    alu_oe     = active & c_alu_oe;
    alu_sub    = active & c_alu_sub;
    or_we      = active & c_or_we;
    instr_done = active & last;
    t_state    = state;
    halted     = (state == HALT);
    instr_count = count;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state  <= T1;
      op_q   <= 4'd0;
      step_q <= 1'b0;
      count  <= 8'd0;
    end else begin
      step_q <= step;
      if (active) begin
        state <= state_nxt;
        if (state == T4) op_q <= ir_opcode;
        if (last) count <= count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (EARLY_END=0 and 1) share stimulus and
// are compared against an instruction-position reference model.
module tb_control_sequencer;

  localparam int B_PC_INC = 11, B_PC_OE = 10, B_MAR_WE = 9, B_MEM_OE = 8;
  localparam int B_IR_WE = 7, B_IR_OE = 6, B_ACC_WE = 5, B_ACC_OE = 4;
  localparam int B_BREG_WE = 3, B_ALU_OE = 2, B_ALU_SUB = 1, B_OR_WE = 0;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       run = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [3:0] ir_opcode = 4'd0;

  wire [11:0] w0, w1;
  wire [2:0]  t0, t1;
  wire        h0, h1, d0, d1;
  wire [7:0]  c0, c1;

  logic [11:0] dw [2];
  logic [2:0]  dt [2];
  logic        dh [2];
  logic        dd [2];
  logic [7:0]  dc [2];

  assign dw[0] = w0; assign dw[1] = w1;
  assign dt[0] = t0; assign dt[1] = t1;
  assign dh[0] = h0; assign dh[1] = h1;
  assign dd[0] = d0; assign dd[1] = d1;
  assign dc[0] = c0; assign dc[1] = c1;

  control_sequencer #(.EARLY_END(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .run(run), .step_mode(step_mode), .step(step),
    .ir_opcode(ir_opcode),
    .pc_inc(w0[11]), .pc_oe(w0[10]), .mar_we(w0[9]), .mem_oe(w0[8]),
    .ir_we(w0[7]), .ir_oe(w0[6]), .acc_we(w0[5]), .acc_oe(w0[4]),
    .breg_we(w0[3]), .alu_oe(w0[2]), .alu_sub(w0[1]), .or_we(w0[0]),
    .t_state(t0), .halted(h0), .instr_done(d0), .instr_count(c0)
  );

  control_sequencer #(.EARLY_END(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .run(run), .step_mode(step_mode), .step(step),
    .ir_opcode(ir_opcode),
    .pc_inc(w1[11]), .pc_oe(w1[10]), .mar_we(w1[9]), .mem_oe(w1[8]),
    .ir_we(w1[7]), .ir_oe(w1[6]), .acc_we(w1[5]), .acc_oe(w1[4]),
    .breg_we(w1[3]), .alu_oe(w1[2]), .alu_sub(w1[1]), .or_we(w1[0]),
    .t_state(t1), .halted(h1), .instr_done(d1), .instr_count(c1)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: position k within the current instruction, retired count, halt flag.
  int          mk [2];
  bit          mhalt [2];
  int          mcount [2];
  logic [3:0]  mop [2];
  bit          mstepq;
  bit          evaled;
  bit          e_act [2];
  bit          e_done [2];
  logic [11:0] e_word [2];
  logic [2:0]  e_t [2];
  int          e_len [2];
  logic [3:0]  e_op [2];

  initial begin
    for (int e = 0; e < 2; e++) begin
      mk[e] = 0; mhalt[e] = 0; mcount[e] = 0; mop[e] = 4'd0;
    end
    mstepq = 0;
    evaled = 0;
  end

  function automatic int instr_len(logic [3:0] op, int e);
    if (op == 4'hF) return 4;
    if (e == 0) return 6;
    case (op)
      4'h0:       return 5;
      4'h1, 4'h2: return 6;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [11:0] word_of(logic [3:0] op, int k);
    logic [11:0] w;
    bit alu;
    w = '0;
    alu = (op == 4'h1) || (op == 4'h2);
    case (k)
      0: begin w[B_PC_OE] = 1'b1; w[B_MAR_WE] = 1'b1; end
      1: w[B_PC_INC] = 1'b1;
      2: begin w[B_MEM_OE] = 1'b1; w[B_IR_WE] = 1'b1; end
      3: begin
        if (alu || op == 4'h0) begin w[B_IR_OE] = 1'b1; w[B_MAR_WE] = 1'b1; end
        else if (op == 4'hE) begin w[B_ACC_OE] = 1'b1; w[B_OR_WE] = 1'b1; end
      end
      4: begin
        if (op == 4'h0) begin w[B_MEM_OE] = 1'b1; w[B_ACC_WE] = 1'b1; end
        else if (alu) begin
          w[B_MEM_OE] = 1'b1; w[B_BREG_WE] = 1'b1; w[B_ALU_SUB] = (op == 4'h2);
        end
      end
      5: if (alu) begin
        w[B_ALU_OE] = 1'b1; w[B_ACC_WE] = 1'b1; w[B_ALU_SUB] = (op == 4'h2);
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic model_eval();
    bit rise, adv;
    rise = step && !mstepq;
    adv  = run && (step_mode ? rise : 1'b1);
    for (int e = 0; e < 2; e++) begin
      e_op[e]   = (mk[e] == 3) ? ir_opcode : mop[e];
      e_len[e]  = instr_len(e_op[e], e);
      e_act[e]  = adv && RESET && !mhalt[e];
      e_word[e] = e_act[e] ? word_of(e_op[e], mk[e]) : 12'd0;
      e_done[e] = e_act[e] && (mk[e] == e_len[e] - 1);
      e_t[e]    = mhalt[e] ? 3'd7 : 3'(mk[e] + 1);
    end
  endtask

  task automatic model_clock();
    if (!RESET) begin
      mstepq = 0;
      for (int e = 0; e < 2; e++) begin
        mk[e] = 0; mhalt[e] = 0; mcount[e] = 0; mop[e] = 4'd0;
      end
    end else begin
      mstepq = step;
      for (int e = 0; e < 2; e++) begin
        if (e_act[e]) begin
          if (mk[e] == 3) mop[e] = ir_opcode;
          if (mk[e] == e_len[e] - 1) begin
            mcount[e] = (mcount[e] + 1) % 256;
            if (e_op[e] == 4'hF) mhalt[e] = 1;
            else mk[e] = 0;
          end else begin
            mk[e] = mk[e] + 1;
          end
        end
      end
    end
  endtask

  // One clock cycle: retire the previous cycle in the model, then apply new inputs.
  task automatic setin(input bit rst_n, input bit r, input bit sm, input bit st,
                       input logic [3:0] op);
    if (evaled) begin
      @(posedge CLK);
      model_clock();
    end
    @(negedge CLK);
    RESET = rst_n; run = r; step_mode = sm; step = st; ir_opcode = op;
    #2;
    model_eval();
    evaled = 1;
  endtask

  task automatic do_reset();
    setin(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    setin(1'b0, 1'b1, 1'b0, 1'b1, 4'h1);
    setin(1'b0, 1'b1, 1'b0, 1'b0, 4'h2);
    for (int e = 0; e < 2; e++) begin
      checks++; if (dt[e] !== 3'd1) begin errors++; $display("FAIL reset_t dut%0d got %0d want 1", e, dt[e]); end
      checks++; if (dh[e] !== 1'b0) begin errors++; $display("FAIL reset_halted dut%0d got %b want 0", e, dh[e]); end
      checks++; if (dc[e] !== 8'd0) begin errors++; $display("FAIL reset_count dut%0d got %0d want 0", e, dc[e]); end
      checks++; if (dd[e] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d got %b want 0", e, dd[e]); end
      checks++; if (dw[e] !== 12'd0) begin errors++; $display("FAIL reset_word dut%0d got %h want 000", e, dw[e]); end
    end
  endtask

  task automatic test_add();
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      setin(1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
      for (int e = 0; e < 2; e++) begin
        checks++; if (dw[e] !== e_word[e]) begin errors++; $display("FAIL add_word dut%0d cyc%0d got %h want %h", e, c, dw[e], e_word[e]); end
        checks++; if (dd[e] !== (c == 6)) begin errors++; $display("FAIL add_done dut%0d cyc%0d got %b want %b", e, c, dd[e], c == 6); end
      end
    end
    setin(1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
    for (int e = 0; e < 2; e++) begin
      checks++; if (dc[e] !== 8'd1) begin errors++; $display("FAIL add_count dut%0d got %0d want 1", e, dc[e]); end
      checks++; if (dt[e] !== 3'd1) begin errors++; $display("FAIL add_t dut%0d got %0d want 1", e, dt[e]); end
    end
  endtask

  task automatic test_step();
    int nz;
    nz = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      setin(1'b1, 1'b1, 1'b1, 1'b1, 4'h3);
      if (dw[0] != 12'd0) nz++;
      checks++; if (dw[0] !== e_word[0]) begin errors++; $display("FAIL step_word cyc%0d got %h want %h", c, dw[0], e_word[0]); end
    end
    checks++; if (nz !== 1) begin errors++; $display("FAIL step_nonzero_cycles got %0d want 1", nz); end
    setin(1'b1, 1'b1, 1'b1, 1'b0, 4'h3);
    checks++; if (dt[0] !== 3'd2) begin errors++; $display("FAIL step_t got %0d want 2", dt[0]); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      setin(1'b1, 1'b1, 1'b0, 1'b0, (c <= 6) ? 4'h0 : 4'hF);
      for (int e = 0; e < 2; e++) begin
        checks++; if (dw[e] !== e_word[e]) begin errors++; $display("FAIL halt_seq_word dut%0d cyc%0d got %h want %h", e, c, dw[e], e_word[e]); end
        checks++; if (dd[e] !== e_done[e]) begin errors++; $display("FAIL halt_seq_done dut%0d cyc%0d got %b want %b", e, c, dd[e], e_done[e]); end
      end
    end
    for (int c = 0; c < 20; c++) begin
      setin(1'b1, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom));
      for (int e = 0; e < 2; e++) begin
        checks++; if (dw[e] !== 12'd0) begin errors++; $display("FAIL halt_word dut%0d got %h want 000", e, dw[e]); end
        checks++; if (dt[e] !== 3'd7) begin errors++; $display("FAIL halt_t dut%0d got %0d want 7", e, dt[e]); end
        checks++; if (dh[e] !== 1'b1) begin errors++; $display("FAIL halt_flag dut%0d got %b want 1", e, dh[e]); end
        checks++; if (dc[e] !== 8'd2) begin errors++; $display("FAIL halt_count dut%0d got %0d want 2", e, dc[e]); end
      end
    end
  endtask

  task automatic test_early_out();
    logic [11:0] want;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      setin(1'b1, 1'b1, 1'b0, 1'b0, 4'hE);
      checks++; if (dw[1] !== e_word[1]) begin errors++; $display("FAIL early_word cyc%0d got %h want %h", c, dw[1], e_word[1]); end
    end
    want = '0; want[B_ACC_OE] = 1'b1; want[B_OR_WE] = 1'b1;
    checks++; if (dw[1] !== want) begin errors++; $display("FAIL early_t4_word got %h want %h", dw[1], want); end
    checks++; if (dd[1] !== 1'b1) begin errors++; $display("FAIL early_done got %b want 1", dd[1]); end
    setin(1'b1, 1'b1, 1'b0, 1'b0, 4'hE);
    checks++; if (dt[1] !== 3'd1) begin errors++; $display("FAIL early_next_t got %0d want 1", dt[1]); end
    checks++; if (dt[0] !== 3'd5) begin errors++; $display("FAIL late_next_t got %0d want 5", dt[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 1; c <= 4; c++) setin(1'b1, 1'b1, 1'b0, 1'b0, 4'h2);
    setin(1'b0, 1'b1, 1'b0, 1'b0, 4'h2);
    checks++; if (dt[0] !== 3'd5) begin errors++; $display("FAIL mid_t5 got %0d want 5", dt[0]); end
    checks++; if (dw[0] !== 12'd0) begin errors++; $display("FAIL mid_word_in_reset got %h want 000", dw[0]); end
    setin(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    checks++; if (dt[0] !== 3'd1) begin errors++; $display("FAIL mid_after_t got %0d want 1", dt[0]); end
    checks++; if (dc[0] !== 8'd0) begin errors++; $display("FAIL mid_after_count got %0d want 0", dc[0]); end
    checks++; if (dw[0][B_ALU_SUB] !== 1'b0) begin errors++; $display("FAIL mid_alu_sub got %b want 0", dw[0][B_ALU_SUB]); end
    setin(1'b1, 1'b1, 1'b0, 1'b0, 4'h2);
    checks++; if (dw[0] !== e_word[0]) begin errors++; $display("FAIL mid_fetch_word got %h want %h", dw[0], e_word[0]); end
  endtask

  task automatic test_wrap();
    int dones;
    dones = 0;
    do_reset();
    for (int c = 0; c < 256 * 6; c++) begin
      setin(1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
      if (dd[0] === 1'b1) dones++;
      for (int e = 0; e < 2; e++) begin
        checks++; if (dw[e] !== e_word[e]) begin errors++; $display("FAIL wrap_word dut%0d cyc%0d got %h want %h", e, c, dw[e], e_word[e]); end
        checks++; if (dd[e] !== e_done[e]) begin errors++; $display("FAIL wrap_done dut%0d cyc%0d got %b want %b", e, c, dd[e], e_done[e]); end
        checks++; if (dc[e] !== 8'(mcount[e])) begin errors++; $display("FAIL wrap_count dut%0d cyc%0d got %0d want %0d", e, c, dc[e], mcount[e]); end
      end
    end
    setin(1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    checks++; if (dones !== 256) begin errors++; $display("FAIL wrap_dones got %0d want 256", dones); end
    checks++; if (dc[0] !== 8'd0) begin errors++; $display("FAIL wrap_final got %0d want 0", dc[0]); end
    checks++; if (dc[1] !== 8'd128) begin errors++; $display("FAIL wrap_final_early got %0d want 128", dc[1]); end
  endtask

  task automatic test_random();
    logic [3:0] ops [6];
    logic [3:0] op;
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE; ops[4] = 4'hF; ops[5] = 4'h7;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      op = ($urandom_range(3) == 0) ? 4'($urandom) : ops[$urandom_range(5)];
      if (op == 4'hF && $urandom_range(3) != 0) op = 4'h1;
      setin(($urandom_range(63) != 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
            1'($urandom_range(1)), op);
      for (int e = 0; e < 2; e++) begin
        checks++; if (dw[e] !== e_word[e]) begin errors++; $display("FAIL rnd_word dut%0d cyc%0d got %h want %h", e, c, dw[e], e_word[e]); end
        checks++; if (dt[e] !== e_t[e]) begin errors++; $display("FAIL rnd_t dut%0d cyc%0d got %0d want %0d", e, c, dt[e], e_t[e]); end
        checks++; if (dh[e] !== mhalt[e]) begin errors++; $display("FAIL rnd_halted dut%0d cyc%0d got %b want %b", e, c, dh[e], mhalt[e]); end
        checks++; if (dd[e] !== e_done[e]) begin errors++; $display("FAIL rnd_done dut%0d cyc%0d got %b want %b", e, c, dd[e], e_done[e]); end
        checks++; if (dc[e] !== 8'(mcount[e])) begin errors++; $display("FAIL rnd_count dut%0d cyc%0d got %0d want %0d", e, c, dc[e], mcount[e]); end
        checks++;
        if ($countones({dw[e][B_PC_OE], dw[e][B_MEM_OE], dw[e][B_IR_OE], dw[e][B_ACC_OE], dw[e][B_ALU_OE]}) > 1) begin
          errors++; $display("FAIL rnd_oe_onehot dut%0d cyc%0d got %h want at most one oe", e, c, dw[e]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_step();
    test_halt();
    test_early_out();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
